// File: rtl/eviction_write_buffer_fill.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | eviction_write_buffer_fill                                                |
// | Producer side of the L2 eviction write buffer: FIFO of dirty lines with   |
// | newest-match read lookup. Optional macro: EWB_FORWARD_EN (read forwarding)|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module eviction_write_buffer_fill #(
    parameter int DEPTH       = 2,
    parameter int LINE_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l2_evict_req,
    input  logic [31:0]           l2_evict_address,
    input  logic [LINE_WIDTH-1:0] l2_evict_data,
    output logic                  l2_evict_ack,
    input  logic                  l2_read_req,
    input  logic [31:0]           l2_read_address,
    output logic                  l2_read_hit,
    output logic [LINE_WIDTH-1:0] l2_read_data,
    output logic                  read_conflict,
    input  logic                  send_evicted_line_pmem,
    input  logic                  complete_eviction,
    output logic                  ewb_valid,
    output logic [31:0]           ewb_address,
    output logic [LINE_WIDTH-1:0] ewb_data,
    output logic                  full
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W+1)'(DEPTH);
    localparam logic [0:0]         c_S_ACCEPT = 1'b0;
    localparam logic [0:0]         c_S_ACKED  = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  r_ack;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic [DEPTH-1:0]      r_valid;
    logic [31:0]           r_addr [DEPTH];
    logic [LINE_WIDTH-1:0] r_data [DEPTH];

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH-1:0]      w_match;
    logic                  w_any_match;

    assign w_full = (r_count == c_FULL);
    // Pop only ever moves rd_ptr; a push while non-empty and not full targets a different slot.
    assign w_pop  = complete_eviction && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_ACCEPT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            c_S_ACCEPT: begin
                if (l2_evict_req && !w_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = c_S_ACKED;
                end
            end
            c_S_ACKED: w_state_nxt = c_S_ACCEPT;
            default:   w_state_nxt = c_S_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            r_ack <= w_push;
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= l2_evict_address;
            r_data[r_wr_ptr] <= l2_evict_data;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_match
            assign w_match[g] = l2_read_req && r_valid[g] &&
                (r_addr[g][31:OFFSET_BITS] == l2_read_address[31:OFFSET_BITS]);
        end
    endgenerate

    assign w_any_match = |w_match;

`ifdef EWB_FORWARD_EN
    logic [c_PTR_W-1:0] w_sel;

    // Walk oldest to newest so the last hit seen is the newest copy.
    always_comb begin
        w_sel = r_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[r_rd_ptr + c_PTR_W'(i)]) w_sel = r_rd_ptr + c_PTR_W'(i);
        end
    end

    assign l2_read_hit   = w_any_match;
    assign l2_read_data  = w_any_match ? r_data[w_sel] : '0;
    assign read_conflict = 1'b0;
`else
    assign l2_read_hit   = 1'b0;
    assign l2_read_data  = '0;
    assign read_conflict = w_any_match;
`endif

    assign l2_evict_ack = r_ack;
    assign ewb_valid    = (r_count != '0);
    assign full         = w_full;
    assign ewb_address  = r_addr[r_rd_ptr];
    assign ewb_data     = r_data[r_rd_ptr];

    logic w_unused_ok;
    assign w_unused_ok = ^{send_evicted_line_pmem, l2_read_address[OFFSET_BITS-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_eviction_write_buffer_fill.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_eviction_write_buffer_fill                                             |
// | Directed self-checking bench for eviction_write_buffer_fill (DEPTH=2).   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_eviction_write_buffer_fill;

    localparam int c_LW = 256;
    localparam logic [c_LW-1:0] c_DATA_A = {8{32'hAAAA_0001}};
    localparam logic [c_LW-1:0] c_DATA_B = {8{32'hBBBB_0002}};
    localparam logic [c_LW-1:0] c_DATA_C = {8{32'hCCCC_0003}};
    localparam logic [c_LW-1:0] c_DATA_D = {8{32'hDDDD_0004}};
    localparam logic [c_LW-1:0] c_DATA_E = {8{32'hEEEE_0005}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            l2_evict_req = 1'b0;
    logic [31:0]     l2_evict_address = '0;
    logic [c_LW-1:0] l2_evict_data = '0;
    logic            l2_evict_ack;
    logic            l2_read_req = 1'b0;
    logic [31:0]     l2_read_address = '0;
    logic            l2_read_hit;
    logic [c_LW-1:0] l2_read_data;
    logic            read_conflict;
    logic            send_evicted_line_pmem = 1'b0;
    logic            complete_eviction = 1'b0;
    logic            ewb_valid;
    logic [31:0]     ewb_address;
    logic [c_LW-1:0] ewb_data;
    logic            full;

    int r_checks   = 0;
    int r_failures = 0;

    eviction_write_buffer_fill #(
        .DEPTH(2), .LINE_WIDTH(c_LW), .OFFSET_BITS(5)
    ) u_dut (
        .clk                    (clk),
        .rst                    (rst),
        .l2_evict_req           (l2_evict_req),
        .l2_evict_address       (l2_evict_address),
        .l2_evict_data          (l2_evict_data),
        .l2_evict_ack           (l2_evict_ack),
        .l2_read_req            (l2_read_req),
        .l2_read_address        (l2_read_address),
        .l2_read_hit            (l2_read_hit),
        .l2_read_data           (l2_read_data),
        .read_conflict          (read_conflict),
        .send_evicted_line_pmem (send_evicted_line_pmem),
        .complete_eviction      (complete_eviction),
        .ewb_valid              (ewb_valid),
        .ewb_address            (ewb_address),
        .ewb_data               (ewb_data),
        .full                   (full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [c_LW-1:0] got, input logic [c_LW-1:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic evict(input logic [31:0] a, input logic [c_LW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        l2_evict_req = 1'b1; l2_evict_address = a; l2_evict_data = d;
        do begin
            @(negedge clk);
            n++;
        end while (!l2_evict_ack && n < 20);
        check_eq("evict_ack", l2_evict_ack, 1);
        l2_evict_req = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk); complete_eviction = 1'b1;
        @(negedge clk); complete_eviction = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] a, input logic [c_LW-1:0] d);
        check_eq({tag, "_valid"}, ewb_valid, 1);
        check_eq({tag, "_addr"}, ewb_address, a);
        check_eq({tag, "_data"}, ewb_data, d);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ack", l2_evict_ack, 0);
        check_eq("rst_valid", ewb_valid, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_conflict", read_conflict, 0);
        rst = 1'b0;

        // Single evict: ack exactly one cycle after the sampled req
        @(negedge clk);
        l2_evict_req = 1'b1; l2_evict_address = 32'h0000_1040; l2_evict_data = c_DATA_A;
        check_eq("t1_ack_before", l2_evict_ack, 0);
        @(negedge clk);
        check_eq("t1_ack", l2_evict_ack, 1);
        head("t1_head", 32'h0000_1040, c_DATA_A);
        check_eq("t1_full", full, 0);
        l2_evict_req = 1'b0;
        @(negedge clk);
        check_eq("t1_ack_pulse", l2_evict_ack, 0);
        pop();
        check_eq("t1_empty", ewb_valid, 0);

        // Fill, stall on full, accept the cycle after the pop
        evict(32'h0000_0100, c_DATA_A);
        evict(32'h0000_0200, c_DATA_B);
        check_eq("t2_full", full, 1);
        @(negedge clk);
        l2_evict_req = 1'b1; l2_evict_address = 32'h0000_0300; l2_evict_data = c_DATA_C;
        repeat (3) @(negedge clk);
        check_eq("t2_stall_ack", l2_evict_ack, 0);
        check_eq("t2_stall_full", full, 1);
        complete_eviction = 1'b1;
        @(negedge clk);
        complete_eviction = 1'b0;
        check_eq("t2_pop_ack", l2_evict_ack, 0);
        check_eq("t2_pop_full", full, 0);
        head("t2_head", 32'h0000_0200, c_DATA_B);
        @(negedge clk);
        check_eq("t2_late_ack", l2_evict_ack, 1);
        check_eq("t2_refull", full, 1);
        head("t2_head_keep", 32'h0000_0200, c_DATA_B);
        l2_evict_req = 1'b0;
        pop();
        head("t2_head_300", 32'h0000_0300, c_DATA_C);
        pop();
        check_eq("t2_empty", ewb_valid, 0);

        // Same line evicted twice: newest copy forwarded, FIFO drain order
        evict(32'h0000_1040, c_DATA_A);
        evict(32'h0000_105C, c_DATA_B);
        @(negedge clk);
        l2_read_req = 1'b1; l2_read_address = 32'h0000_1044;
        #1;
`ifdef EWB_FORWARD_EN
        check_eq("t3_hit", l2_read_hit, 1);
        check_eq("t3_data", l2_read_data, c_DATA_B);
        check_eq("t3_conflict", read_conflict, 0);
`else
        check_eq("t3_hit", l2_read_hit, 0);
        check_eq("t3_data", l2_read_data, 0);
        check_eq("t3_conflict", read_conflict, 1);
`endif
        l2_read_address = 32'h0000_1060;
        #1;
        check_eq("t3_miss_hit", l2_read_hit, 0);
        check_eq("t3_miss_conflict", read_conflict, 0);
        l2_read_req = 1'b0;
        head("t3_drain_a", 32'h0000_1040, c_DATA_A);
        pop();
        head("t3_drain_b", 32'h0000_105C, c_DATA_B);
        pop();
        check_eq("t3_empty", ewb_valid, 0);

        // Head stable while draining and a second evict is pushed
        evict(32'h0000_3000, c_DATA_C);
        @(negedge clk);
        send_evicted_line_pmem = 1'b1;
        l2_evict_req = 1'b1; l2_evict_address = 32'h0000_4000; l2_evict_data = c_DATA_D;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t4_addr_stable", ewb_address, 32'h0000_3000);
            check_eq("t4_data_stable", ewb_data, c_DATA_C);
            if (l2_evict_ack) l2_evict_req = 1'b0;
        end
        check_eq("t4_pushed_full", full, 1);
        send_evicted_line_pmem = 1'b0;
        pop();
        head("t4_head_next", 32'h0000_4000, c_DATA_D);
        pop();

        // Pop while empty is ignored
        pop();
        check_eq("t5_empty_valid", ewb_valid, 0);
        check_eq("t5_empty_full", full, 0);
        evict(32'h0000_6000, c_DATA_A);
        head("t5_after_empty_pop", 32'h0000_6000, c_DATA_A);
        pop();
        check_eq("t5_count_zero", ewb_valid, 0);

        // Asynchronous reset mid-drain
        evict(32'h0000_7000, c_DATA_B);
        evict(32'h0000_8000, c_DATA_C);
        @(negedge clk);
        send_evicted_line_pmem = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", ewb_valid, 0);
        check_eq("t5_rst_full", full, 0);
        check_eq("t5_rst_ack", l2_evict_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        send_evicted_line_pmem = 1'b0;
        evict(32'h0000_5000, c_DATA_E);
        head("t5_post_rst", 32'h0000_5000, c_DATA_E);
        check_eq("t5_post_rst_full", full, 0);
        pop();

        // Conflict vs forward on a single buffered line
        evict(32'h0000_2000, c_DATA_D);
        @(negedge clk);
        l2_read_req = 1'b1; l2_read_address = 32'h0000_2010;
        #1;
`ifdef EWB_FORWARD_EN
        check_eq("t6_hit", l2_read_hit, 1);
        check_eq("t6_data", l2_read_data, c_DATA_D);
        check_eq("t6_conflict", read_conflict, 0);
`else
        check_eq("t6_conflict", read_conflict, 1);
        check_eq("t6_hit", l2_read_hit, 0);
`endif
        complete_eviction = 1'b1;
        @(negedge clk);
        complete_eviction = 1'b0;
        check_eq("t6_conflict_clear", read_conflict, 0);
        check_eq("t6_hit_clear", l2_read_hit, 0);
        check_eq("t6_data_clear", l2_read_data, 0);
        l2_read_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
